// File: rtl/fb_err_pkg.sv
// fb_err_pkg: shared encodings, primed-FSM states and saturation helper for fb_err_calc
package fb_err_pkg;
  localparam logic EC_MODE_DELTA = 1'b0;
  localparam logic EC_MODE_PHASE = 1'b1;
  typedef enum logic {S_EMPTY, S_PRIMED} primed_state_t;
  // Clamp a sign-extended value of in_w bits to the signed range of out_w bits
  function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int in_w, input int out_w);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    return (in_w <= out_w) ? v : (v > hi ? hi : (v < lo ? lo : v));
  endfunction
endpackage

// File: rtl/fb_win_avg.sv
// fb_win_avg: accumulates 2^AVG_LOG2 samples and emits the floored window average with a one-cycle strobe
module fb_win_avg #(
  parameter int IN_W     = 12,
  parameter int AVG_LOG2 = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            sample_valid,
  input  logic [IN_W-1:0] adc_in_v,
  output logic [IN_W-1:0] avg,
  output logic            avg_valid
);
  localparam int CW = AVG_LOG2 > 0 ? AVG_LOG2 : 1;
  localparam int AW = IN_W + AVG_LOG2;
  logic [AW-1:0] acc, sum;
  logic [CW-1:0] cnt;
  logic last;
  assign sum  = acc + AW'(adc_in_v);
  assign last = cnt == CW'((1 << AVG_LOG2) - 1);
  // Completing sample reloads the accumulator so the next window starts without a gap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      cnt       <= '0;
      avg       <= '0;
      avg_valid <= 1'b0;
    end else begin
      avg_valid <= !clr && sample_valid && last;
      if (clr) begin
        acc <= '0;
        cnt <= '0;
      end else if (sample_valid) begin
        acc <= last ? '0 : sum;
        cnt <= last ? '0 : cnt + 1'b1;
        if (last) avg <= IN_W'(sum >> AVG_LOG2);
      end
    end
  end
endmodule

// File: rtl/fb_err_calc.sv
// fb_err_calc: windowed-average error E and error change EC for the fuzzy rule engine
// Optional deadband on E enabled by defining FB_ERR_DEADBAND_EN
module fb_err_calc
  import fb_err_pkg::*;
#(
  parameter int IN_W     = 12,
  parameter int OUT_W    = 16,
  parameter int AVG_LOG2 = 2,
  parameter int DEADBAND = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    sample_valid,
  input  logic [IN_W-1:0]         adc_in_v,
  input  logic [IN_W-1:0]         setpoint,
  input  logic signed [OUT_W-1:0] phase_diff,
  input  logic                    ec_mode,
  output logic signed [OUT_W-1:0] E,
  output logic signed [OUT_W-1:0] EC,
  output logic                    out_valid,
  output logic                    primed
);
`ifdef FB_ERR_DEADBAND_EN
  localparam bit DB_EN = 1'b1;
`else
  localparam bit DB_EN = 1'b0;
`endif
  logic [IN_W-1:0] avg;
  logic avg_valid, s1_v, s1_mode, in_band;
  logic signed [IN_W:0] diff;
  logic signed [OUT_W-1:0] s1_ph, e_sat, e_new, e_prev, ec_new;
  logic signed [OUT_W:0] delta;
  primed_state_t state;

  fb_win_avg #(.IN_W(IN_W), .AVG_LOG2(AVG_LOG2)) u_avg (
    .clk(clk), .rst(rst), .clr(clr), .sample_valid(sample_valid),
    .adc_in_v(adc_in_v), .avg(avg), .avg_valid(avg_valid)
  );

  always_comb begin
    e_sat   = OUT_W'(sat(64'(diff), IN_W + 1, OUT_W));
    in_band = int'(e_sat) > -DEADBAND && int'(e_sat) < DEADBAND;
    e_new   = DB_EN && in_band ? '0 : e_sat;
    delta   = (OUT_W + 1)'(e_new) - (OUT_W + 1)'(e_prev);
    ec_new  = s1_mode == EC_MODE_PHASE ? s1_ph
            : (state == S_PRIMED ? OUT_W'(sat(64'(delta), OUT_W + 1, OUT_W)) : '0);
  end

  // clr drops whatever is in flight; E/EC keep their last presented values
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      diff      <= '0;
      s1_v      <= 1'b0;
      s1_ph     <= '0;
      s1_mode   <= EC_MODE_DELTA;
      E         <= '0;
      EC        <= '0;
      out_valid <= 1'b0;
      e_prev    <= '0;
      state     <= S_EMPTY;
    end else begin
      s1_v      <= avg_valid && !clr;
      out_valid <= s1_v && !clr;
      if (avg_valid) begin
        diff    <= $signed({1'b0, setpoint}) - $signed({1'b0, avg});
        s1_ph   <= phase_diff;
        s1_mode <= ec_mode;
      end
      if (clr) begin
        e_prev <= '0;
        state  <= S_EMPTY;
      end else if (s1_v) begin
        E      <= e_new;
        EC     <= ec_new;
        e_prev <= e_new;
        state  <= S_PRIMED;
      end
    end
  end

  assign primed = state == S_PRIMED;
endmodule

// File: doc/fb_err_calc.md
Name: fb_err_calc

Overview:
Parametrised successor of the fuzzy-controller feedback front end in the frequency-tracking loop. It averages 2^AVG_LOG2 ADC samples per window and computes the error E = setpoint − average. It also computes the error change EC, taken either from the E difference between windows or from the phase-detector difference, selected at run time. Results are saturated to OUT_W signed bits and emitted with a one-cycle valid strobe to the fuzzy rule engine.

Parameters:
IN_W, 12, ADC sample and setpoint width (unsigned).
OUT_W, 16, E/EC/phase_diff width (signed two's complement).
AVG_LOG2, 2, log2 of samples per averaging window (0 = no averaging).
DEADBAND, 8, |E| threshold below which E is forced to 0 (used only with FB_ERR_DEADBAND_EN).

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
clr  in  1  synchronous clear: restart window, forget previous E
sample_valid  in  1  adc_in_v qualifier, one sample per high cycle
adc_in_v  in  IN_W  unsigned ADC sample
setpoint  in  IN_W  unsigned target level, sampled at window completion
phase_diff  in  OUT_W  signed phase-detector difference, sampled at window completion
ec_mode  in  1  0: EC = E − E_prev; 1: EC = phase_diff
E  out  OUT_W  signed error, registered
EC  out  OUT_W  signed error change, registered
out_valid  out  1  one-cycle strobe marking new E/EC
primed  out  1  high once at least one E has been produced since reset/clr

Behaviour:
- Reset (async, rst=1): E=0, EC=0, out_valid=0, primed=0, accumulator=0, sample counter=0, E_prev=0. Outputs hold their values between strobes.
- Accumulator: width IN_W+AVG_LOG2 unsigned. On sample_valid it adds adc_in_v and increments the counter (AVG_LOG2 bits, wraps). The sample that brings the counter to 2^AVG_LOG2−1 completes the window. The average is the full sum including that sample, logical-shifted right by AVG_LOG2 (floor). The accumulator then reloads to 0 on the same edge, so the next cycle's sample_valid starts a new window with no gap.
- Pipeline stage 1 (edge after window completion): diff = setpoint − avg, computed IN_W+1 signed. Latch phase_diff and ec_mode.
- Pipeline stage 2 (next edge): E_new = sat_OUT_W(diff), with deadband applied if enabled. EC = ec_mode ? phase_diff : (primed ? sat_OUT_W(E_new − E_prev) computed OUT_W+1 signed : 0). Assert out_valid for one cycle, set E_prev=E_new, set primed=1.
- Latency: out_valid is high 2 cycles after the clock edge that samples the window-completing sample. The block is fully pipelined with no stall. AVG_LOG2=0 with back-to-back samples yields back-to-back strobes.
- Saturation: values above 2^(OUT_W−1)−1 clamp to max; values below −2^(OUT_W−1) clamp to min. When OUT_W ≥ IN_W+2, E never saturates.
- Primed FSM has 2 states. S_EMPTY → S_PRIMED on the first stage-2 strobe. Any state → S_EMPTY on clr or rst.
- clr: zeroes the accumulator and counter and kills any in-flight stage-1/stage-2 result (no strobe). Returns to S_EMPTY and zeroes E_prev. E/EC outputs keep their last values. A sample_valid in the same cycle as clr is discarded.
- rst mid-window or mid-pipeline: everything returns to reset values immediately. No strobe is generated from partial data.

Optional Feature:
FB_ERR_DEADBAND_EN
- Defined: after saturation, if −DEADBAND < E_new < DEADBAND then E_new=0. E_prev stores the post-deadband value, so EC in mode 0 is computed from deadbanded values.
- Undefined: no deadband logic. The DEADBAND parameter is ignored.

Decomposition:
- Package fb_err_pkg: ec_mode encodings (EC_MODE_DELTA=0, EC_MODE_PHASE=1), primed-FSM state typedef, and a sat function parametrised by input/output width.
- Sub-module fb_win_avg: accumulator, counter and clr handling. Outputs avg plus a one-cycle avg_valid. The parent holds the two pipeline stages and the FSM.

Test Plan:
- Reset: assert rst mid-run → E=0, EC=0, out_valid=0, primed=0 asynchronously; no strobe afterwards until a full new window.
- Defaults: setpoint=2048, samples 2000, 2004, 1996, 2000 on consecutive cycles → out_valid 2 cycles after the 4th sample, with E=48, EC=0, primed=1.
- Next window: all samples 2048, ec_mode=0 → E=0, EC=−48. Then four samples of 2100 → E=−52, EC=−52.
- ec_mode=1, phase_diff=−300 at window completion → EC=−300 regardless of the E history.
- OUT_W=8, IN_W=12: setpoint=4095, samples 0 → E=127. Next window: setpoint=0, samples 4095 → E=−128, EC=sat(−255)=−128.
- clr after 2 of 4 samples, then 4 samples of 1000 with setpoint 1000 → exactly one strobe with E=0 and EC=0 (primed was cleared). With FB_ERR_DEADBAND_EN and avg 2043, setpoint 2048 → E=0.
